nrf24_tx_packer: RTL and testbench

- Upstream feeder for the nRF24 radio controller. Packs 16-bit ADC samples in pairs into 32-bit payload words and buffers them in a FIFO.
- Presents words on a valid/ready handshake that connects directly to the controller's tx_payload/tx_valid/tx_ready.
- Flushes a lone pending sample after a timeout so a slow sample stream cannot stall the radio.
- Counts words dropped on FIFO overflow.

---
 rtl/nrf24_pkg.sv | 16 +
 rtl/sync_fifo_fwft.sv | 68 ++++++
 rtl/nrf24_tx_packer.sv | 120 ++++++++++++
 tb/tb_nrf24_tx_packer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrf24_pkg.sv
// Shared types and constants for the nRF24 transmit-side sample packer.
package nrf24_pkg;

    localparam int PAYLOAD_W = 32;
    localparam int SAMPLE_W  = 16;

    // Filler for the upper half of a word flushed with only one sample.
    localparam logic [SAMPLE_W-1:0] PAD_DEFAULT = 16'h8000;

    // Whether the packer is holding a lone first sample.
    typedef enum logic {
        PK_EMPTY = 1'b0,
        PK_HALF  = 1'b1
    } pk_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. Full/empty come from an explicit
// occupancy count, so the pointers can simply wrap modulo the depth.
module sync_fifo_fwft #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);

    localparam int              DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              do_push, do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LEVEL_FULL);
    assign level = level_q;

    // Head word is shown directly; an empty FIFO presents all zeros.
    assign dout = empty ? '0 : mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are meaningless until counted by level_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/nrf24_tx_packer.sv
// Packs pairs of 16-bit ADC samples into 32-bit radio payload words, flushes a
// lone sample padded after a timeout or on request, and buffers the words in a
// FWFT FIFO feeding the radio controller's valid/ready payload input.
module nrf24_tx_packer
    import nrf24_pkg::*;
#(
    parameter int                  ADDR_W  = 4,
    parameter int                  TIMEOUT = 1000,
    parameter logic [SAMPLE_W-1:0] PAD     = PAD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SAMPLE_W-1:0]  adc_data,
    input  logic                 adc_valid,
    input  logic                 flush,
    output logic [PAYLOAD_W-1:0] tx_payload,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [ADDR_W:0]      fifo_level,
    output logic [15:0]          overflow_count
);

    // Timer only ever needs to reach TIMEOUT-1.
    localparam int                 TIMER_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    pk_state_e              state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [SAMPLE_W-1:0]    held_q, held_d;
    logic [15:0]            ovf_q, ovf_d;

    logic                   push;
    logic [PAYLOAD_W-1:0]   push_word;
    logic                   fifo_full, fifo_empty;
    logic                   pop_now;
    logic                   drop;
    logic                   timeout_hit;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TIMER_LAST);

    // Packer next state: a new sample always wins over flush/timeout in HALF.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        held_d    = held_q;
        push      = 1'b0;
        push_word = '0;
        case (state_q)
            PK_EMPTY: begin
                if (adc_valid) begin
                    held_d  = adc_data;
                    timer_d = '0;
                    state_d = PK_HALF;
                end
            end
            PK_HALF: begin
                if (adc_valid) begin
                    push      = 1'b1;
                    push_word = {adc_data, held_q};
                    state_d   = PK_EMPTY;
                end else if (flush || timeout_hit) begin
                    push      = 1'b1;
                    push_word = {PAD, held_q};
                    state_d   = PK_EMPTY;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = PK_EMPTY;
        endcase
    end

    // A word is lost only when the FIFO is full and nothing leaves this cycle.
    always_comb begin
        pop_now = tx_ready && !fifo_empty;
        drop    = push && fifo_full && !pop_now;
        ovf_d   = drop ? sat_inc16(ovf_q) : ovf_q;
    end

    // Control registers: packer state, timer and drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PK_EMPTY;
            timer_q <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ovf_q   <= ovf_d;
        end
    end

    // Held first sample; only meaningful while the packer is in HALF.
    always_ff @(posedge clk) begin
        held_q <= held_d;
    end

    sync_fifo_fwft #(
        .DATA_W (PAYLOAD_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (tx_ready),
        .din   (push_word),
        .dout  (tx_payload),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_valid       = !fifo_empty;
    assign overflow_count = ovf_q;

endmodule

// File: tb/tb_nrf24_tx_packer.sv
// Scoreboard bench for nrf24_tx_packer: the driver predicts every word from the
// pairing/flush/timeout rules, the monitor checks each cycle's outputs.
module tb_nrf24_tx_packer;

    localparam int          AW    = 2;
    localparam int          DEPTH = 1 << AW;
    localparam int          TO    = 8;
    localparam logic [15:0] PAD   = 16'h8000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic        flush = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] tx_payload;
    logic        tx_valid;
    logic [AW:0] fifo_level;
    logic [15:0] overflow_count;

    // Second instance with the timeout disabled.
    logic        z_reset = 1'b1;
    logic [15:0] z_adc_data = '0;
    logic        z_adc_valid = 1'b0;
    logic        z_flush = 1'b0;
    logic        z_tx_ready = 1'b0;
    logic [31:0] z_tx_payload;
    logic        z_tx_valid;
    logic [4:0]  z_fifo_level;
    logic [15:0] z_overflow_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nrf24_tx_packer #(.ADDR_W(AW), .TIMEOUT(TO), .PAD(PAD)) dut (
        .clk            (clk),
        .reset          (reset),
        .adc_data       (adc_data),
        .adc_valid      (adc_valid),
        .flush          (flush),
        .tx_payload     (tx_payload),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .fifo_level     (fifo_level),
        .overflow_count (overflow_count)
    );

    nrf24_tx_packer #(.ADDR_W(4), .TIMEOUT(0)) dut_nto (
        .clk            (clk),
        .reset          (z_reset),
        .adc_data       (z_adc_data),
        .adc_valid      (z_adc_valid),
        .flush          (z_flush),
        .tx_payload     (z_tx_payload),
        .tx_valid       (z_tx_valid),
        .tx_ready       (z_tx_ready),
        .fifo_level     (z_fifo_level),
        .overflow_count (z_overflow_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] exp_q[$];      // words the DUT FIFO should hold, head first
    int          mdl_level = 0; // predicted occupancy for accept/drop decisions
    int          mdl_ovf = 0;
    bit          held_v = 0;
    logic [15:0] held_s = '0;
    int          held_cyc = 0;
    int          cyc = 0;
    bit          pend_v = 0, pend_drop = 0, pend_rst = 0;
    logic [31:0] pend_w = '0;
    bit          mon_en = 0;

    task automatic model_cycle(input bit r, input bit av, input logic [15:0] ad,
                               input bit fl, input bit rdy);
        bit          got;
        bit          pop;
        logic [31:0] w;
        pend_rst  = r;
        pend_v    = 0;
        pend_drop = 0;
        got       = 0;
        w         = '0;
        if (r) begin
            held_v    = 0;
            mdl_level = 0;
            return;
        end
        if (av) begin
            if (held_v) begin
                w = {ad, held_s}; got = 1; held_v = 0;
            end else begin
                held_v = 1; held_s = ad; held_cyc = cyc;
            end
        end else if (held_v && (fl || (TO != 0 && cyc - held_cyc == TO))) begin
            w = {PAD, held_s}; got = 1; held_v = 0;
        end
        pop = rdy && (mdl_level > 0);
        if (pop) mdl_level--;
        if (got) begin
            if (mdl_level < DEPTH) begin
                pend_v = 1; pend_w = w; mdl_level++;
            end else begin
                pend_drop = 1;
            end
        end
    endtask

    task automatic commit();
        if (pend_rst) begin
            exp_q.delete();
            mdl_ovf = 0;
        end else begin
            if (pend_v) exp_q.push_back(pend_w);
            if (pend_drop && mdl_ovf < 65535) mdl_ovf++;
        end
    endtask

    // One clock cycle: drive inputs just after an edge, then apply the edge.
    task automatic step(input bit r, input bit av, input logic [15:0] ad,
                        input bit fl, input bit rdy);
        reset = r; adc_valid = av; adc_data = ad; flush = fl; tx_ready = rdy;
        model_cycle(r, av, ad, fl, rdy);
        @(posedge clk); #1;
        commit();
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, rdy);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("tx_valid", 32'(tx_valid), 32'(exp_q.size() != 0));
            chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
            chk("overflow_count", 32'(overflow_count), 32'(mdl_ovf));
            if (exp_q.size() == 0) begin
                chk("tx_payload_empty", tx_payload, 32'h0);
            end else begin
                chk("tx_payload", tx_payload, exp_q[0]);
                if (tx_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- main stimulus ----------------
    task automatic main_seq();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_payload", tx_payload, 32'h0);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_ovf", 32'(overflow_count), 32'h0);
        mon_en = 1;

        // pairing
        step(0, 1, 16'h1111, 0, 1);
        step(0, 1, 16'h2222, 0, 1);
        chk("pair_valid", 32'(tx_valid), 32'h1);
        chk("pair_word", tx_payload, 32'h2222_1111);
        idle(1, 1);
        chk("pair_one_cycle", 32'(tx_valid), 32'h0);
        idle(2, 1);

        // timeout: sample in relative cycle 0, word visible in cycle 9
        step(0, 1, 16'h00AB, 0, 0);
        idle(7, 0);
        chk("to_not_yet", 32'(tx_valid), 32'h0);
        idle(1, 0);
        chk("to_rise", 32'(tx_valid), 32'h1);
        chk("to_word", tx_payload, 32'h8000_00AB);
        idle(3, 1);

        // flush colliding with second sample
        step(0, 1, 16'h0001, 0, 1);
        step(0, 1, 16'h0002, 1, 1);
        chk("coll_word", tx_payload, 32'h0002_0001);
        idle(12, 1);
        chk("coll_single", 32'(fifo_level), 32'h0);

        // back-pressure and overflow: 6 words into a 4-deep FIFO
        for (int i = 0; i < 12; i++) step(0, 1, 16'h0100 + 16'(i), 0, 0);
        chk("ovf_level", 32'(fifo_level), 32'h4);
        chk("ovf_count", 32'(overflow_count), 32'h2);
        chk("ovf_head", tx_payload, 32'h0101_0100);
        idle(6, 1);
        chk("drain_valid", 32'(tx_valid), 32'h0);
        chk("drain_payload", tx_payload, 32'h0);

        // full with a pop on the cycle a pair completes
        for (int i = 0; i < 8; i++) step(0, 1, 16'h0200 + 16'(i), 0, 0);
        step(0, 1, 16'h0AAA, 0, 0);
        step(0, 1, 16'h0BBB, 0, 1);
        chk("fullpop_level", 32'(fifo_level), 32'h4);
        chk("fullpop_ovf", 32'(overflow_count), 32'h2);
        idle(6, 1);

        // reset mid-operation with 3 words stored and one sample held
        for (int i = 0; i < 7; i++) step(0, 1, 16'h0300 + 16'(i), 0, 0);
        chk("pre_rst_level", 32'(fifo_level), 32'h3);
        step(1, 0, 0, 0, 0);
        chk("mrst_valid", 32'(tx_valid), 32'h0);
        chk("mrst_level", 32'(fifo_level), 32'h0);
        chk("mrst_ovf", 32'(overflow_count), 32'h0);
        step(0, 1, 16'h5555, 0, 0);
        chk("mrst_no_pair", 32'(tx_valid), 32'h0);
        step(0, 0, 0, 1, 0);
        chk("mrst_flush_word", tx_payload, 32'h8000_5555);
        idle(3, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 1) == 1),
                 16'($urandom()),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 6));
        end
        idle(20, 1);
        chk("final_empty", 32'(fifo_level), 32'h0);
        mon_en = 0;
    endtask

    // TIMEOUT=0: a lone sample must wait indefinitely until flushed.
    task automatic nto_seq();
        int seen;
        seen = 0;
        repeat (2) @(posedge clk);
        #1;
        z_reset = 0; z_tx_ready = 1;
        z_adc_valid = 1; z_adc_data = 16'h0C0D;
        @(posedge clk); #1;
        z_adc_valid = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (z_tx_valid) seen++;
        end
        chk("nto_no_emit", 32'(seen), 32'h0);
        @(posedge clk); #1;
        z_flush = 1;
        @(posedge clk); #1;
        z_flush = 0;
        chk("nto_flush_valid", 32'(z_tx_valid), 32'h1);
        chk("nto_flush_word", z_tx_payload, 32'h8000_0C0D);
    endtask

    initial begin
        fork
            main_seq();
            nto_seq();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
